rr_mux_4_1: RTL and testbench

Registered 4-input round-robin arbiter with a 1-bit-select-free AND/OR datapath.
- Four valid/ready producers compete for one output channel.
- The block computes a one-hot grant and steers the winner's word through an AND/OR 4:1 mux of the same gate-level form as mux_4_1.
- It places the result in a one-entry output register.
- It sits directly upstream of the single-consumer stage and supplies both the selected word and the 2-bit select that produced it.

---
 rtl/rr_mux_4_1.sv | 108 ++++++++++
 tb/tb_rr_mux_4_1.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_4_1
// Description : Four-producer round-robin arbiter feeding an AND/OR 4:1 mux
//               into a one-entry output register. Optional per-input grant
//               counters are enabled by defining RR_MUX_GRANT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
`ifdef RR_MUX_GRANT_CNT_EN
    ,
    output logic [31:0]      grant_cnt
`endif
);

    localparam logic [1:0] c_PTR_RST = 2'd3;

    logic [1:0]       r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_sel;

    logic             w_load;
    logic             w_xfer;
    logic [3:0]       w_grant;
    logic             w_found;
    logic [1:0]       w_idx;
    logic [WIDTH-1:0] w_mux;
    logic [1:0]       w_sel;

    assign w_load = ~r_out_valid | out_ready;
    assign w_xfer = w_load & (|in_valid);

    // Search starts just after the last winner; offset 4 wraps back to ptr.
    always_comb begin
        w_grant = 4'b0000;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && in_valid[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign in_ready = w_grant & {4{w_load}} & {4{rst_n}};

    assign w_mux = ({WIDTH{w_grant[0]}} & d0) |
                   ({WIDTH{w_grant[1]}} & d1) |
                   ({WIDTH{w_grant[2]}} & d2) |
                   ({WIDTH{w_grant[3]}} & d3);

    assign w_sel = {w_grant[3] | w_grant[2], w_grant[3] | w_grant[1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= c_PTR_RST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
        end else if (w_xfer) begin
            r_ptr       <= w_sel;
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_sel   <= w_sel;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

`ifdef RR_MUX_GRANT_CNT_EN
    generate
        for (genvar i = 0; i < 4; i++) begin : g_cnt
            logic [7:0] r_cnt;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= 8'd0;
                end else if (w_xfer && w_grant[i]) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            assign grant_cnt[8*i +: 8] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_4_1
// Description : Directed self-checking bench for rr_mux_4_1 (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_4_1;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] d0, d1, d2, d3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;
`ifdef RR_MUX_GRANT_CNT_EN
    logic [31:0] grant_cnt;
`endif

    int tot = 0;
    int bad = 0;

    rr_mux_4_1 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef RR_MUX_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1 time unit later
    // (combinational) or 1 time unit after the rising edge (registered).
    task automatic drive(input logic rn, input logic [3:0] v, input logic rdy);
        @(negedge clk);
        rst_n     = rn;
        in_valid  = v;
        out_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'hF, 1'b1);
            tot++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got=%b exp=0000", in_ready); end
            tick();
            tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
            tot++; if (out_data !== 4'h0 || out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_regs: data=%h sel=%0d exp data=0 sel=0", out_data, out_sel); end
        end
        drive(1'b1, 4'hF, 1'b1);
        tot++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got=%b exp=0001", in_ready); end
        tick();
        tot++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin bad++; $display("FAIL reset_first_word: valid=%b sel=%0d data=%h exp 1/0/1", out_valid, out_sel, out_data); end
        drive(1'b1, 4'h0, 1'b1);
        tot++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL idle_in_ready: got=%b exp=0000", in_ready); end
        tick();
        tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_drain: out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_dat [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'hF, 1'b1);
            tot++; if (in_ready !== (4'b0001 << exp_sel[k])) begin bad++; $display("FAIL rot_grant[%0d]: got=%b exp=%b", k, in_ready, 4'b0001 << exp_sel[k]); end
            tick();
            tot++; if (out_valid !== 1'b1 || out_sel !== exp_sel[k] || out_data !== exp_dat[k]) begin bad++; $display("FAIL rot_out[%0d]: valid=%b sel=%0d data=%h exp 1/%0d/%h", k, out_valid, out_sel, out_data, exp_sel[k], exp_dat[k]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        d2 = 4'hA;
        drive(1'b1, 4'b0100, 1'b1);
        tot++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_fill_grant: got=%b exp=0100", in_ready); end
        tick();
        tot++; if (out_data !== 4'hA || out_sel !== 2'd2) begin bad++; $display("FAIL bp_fill_word: data=%h sel=%0d exp A/2", out_data, out_sel); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'hF, 1'b0);
            tot++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d]: got=%b exp=0000", c, in_ready); end
            tick();
            tot++; if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd2) begin bad++; $display("FAIL bp_hold[%0d]: valid=%b data=%h sel=%0d exp 1/A/2", c, out_valid, out_data, out_sel); end
        end
        drive(1'b1, 4'hF, 1'b1);
        tot++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_grant: got=%b exp=1000", in_ready); end
        tick();
        tot++; if (out_sel !== 2'd3 || out_data !== 4'h4) begin bad++; $display("FAIL bp_release_word: sel=%0d data=%h exp 3/4", out_sel, out_data); end
    endtask

    task automatic test_skip_idle();
        do_reset();
        drive(1'b1, 4'b0001, 1'b1);
        tick();
        drive(1'b1, 4'b0100, 1'b1);
        tot++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL skip_grant2: got=%b exp=0100", in_ready); end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 4'h0, 1'b1);
            tick();
            tot++; if (out_valid !== 1'b0 || out_sel !== 2'd2 || out_data !== 4'hA) begin bad++; $display("FAIL idle_hold[%0d]: valid=%b sel=%0d data=%h exp 0/2/A", c, out_valid, out_sel, out_data); end
        end
        drive(1'b1, 4'b0101, 1'b1);
        tot++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL skip_grant0: got=%b exp=0001", in_ready); end
        tick();
        tot++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin bad++; $display("FAIL skip_word0: valid=%b sel=%0d data=%h exp 1/0/1", out_valid, out_sel, out_data); end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 4'hF, 1'b1);
        tick();
        tot++; if (out_valid !== 1'b1 || out_sel !== 2'd1) begin bad++; $display("FAIL mid_fill: valid=%b sel=%0d exp 1/1", out_valid, out_sel); end
        drive(1'b0, 4'hF, 1'b0);
        tick();
        tot++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin bad++; $display("FAIL mid_reset_regs: valid=%b sel=%0d data=%h exp 0/0/0", out_valid, out_sel, out_data); end
        drive(1'b1, 4'hF, 1'b0);
        tot++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL mid_reset_grant: got=%b exp=0001", in_ready); end
        tick();
        tot++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin bad++; $display("FAIL mid_reset_word: valid=%b sel=%0d data=%h exp 1/0/1", out_valid, out_sel, out_data); end
    endtask

`ifdef RR_MUX_GRANT_CNT_EN
    task automatic test_grant_cnt();
        do_reset();
        tot++; if (grant_cnt !== 32'h0) begin bad++; $display("FAIL cnt_reset: got=%h exp=00000000", grant_cnt); end
        for (int c = 0; c < 256; c++) begin
            drive(1'b1, 4'b0010, 1'b1);
            tick();
            if (c == 254) begin
                tot++; if (grant_cnt !== 32'h0000FF00) begin bad++; $display("FAIL cnt_255: got=%h exp=0000ff00", grant_cnt); end
            end
        end
        tot++; if (grant_cnt !== 32'h0) begin bad++; $display("FAIL cnt_wrap: got=%h exp=00000000", grant_cnt); end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'h0;
        out_ready = 1'b0;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        test_reset();
        test_rotation();
        test_backpressure();
        test_skip_idle();
        test_mid_reset();
`ifdef RR_MUX_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire
